// File: rtl/fp_mult_result_buffer_pkg.sv
// ============================================================================
// Module      : fp_mult_result_buffer_pkg
// Description : Shared status layout and widths for the fp_mult result path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_mult_result_buffer_pkg;

    localparam int STATUS_W = 8;
    localparam int FLAG_W   = 6;
    localparam int Z_W      = 32;

    typedef struct packed {
        logic [1:0] rsvd;
        logic       inexact;
        logic       huge;
        logic       tiny;
        logic       nan;
        logic       inf;
        logic       zero;
    } fp_status_t;

    // Only the defined exception bits take part in sticky accumulation.
    function automatic logic [FLAG_W-1:0] status_flags(input fp_status_t st);
        return {st.inexact, st.huge, st.tiny, st.nan, st.inf, st.zero};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mult_result_buffer_if.sv
// ============================================================================
// Module      : fp_mult_result_buffer_if
// Description : Producer/consumer/status bundle for fp_mult_result_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_mult_result_buffer_if #(
    parameter int CNT_W = 16
);
    import fp_mult_result_buffer_pkg::*;

    logic                in_valid;
    logic [Z_W-1:0]      in_z;
    logic [STATUS_W-1:0] in_status;
    logic                in_ready;
    logic                almost_full;
    logic                out_valid;
    logic                out_ready;
    logic [Z_W-1:0]      out_z;
    logic [STATUS_W-1:0] out_status;
    logic [FLAG_W-1:0]   sticky_flags;
    logic                clear_flags;
    logic [CNT_W-1:0]    result_cnt;
    logic [CNT_W-1:0]    drop_cnt;
    logic                overflow_err;

    // Environment side: drives results and consumer/control inputs.
    modport master (
        output in_valid, in_z, in_status, out_ready, clear_flags,
        input  in_ready, almost_full, out_valid, out_z, out_status,
               sticky_flags, result_cnt, drop_cnt, overflow_err
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_z, in_status, out_ready, clear_flags,
        output in_ready, almost_full, out_valid, out_z, out_status,
               sticky_flags, result_cnt, drop_cnt, overflow_err
    );

endinterface

`default_nettype wire

// File: rtl/fp_result_fifo.sv
// ============================================================================
// Module      : fp_result_fifo
// Description : Generic DEPTH x WIDTH first-word-fall-through FIFO with count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         wdata,
    output logic      [WIDTH-1:0]         rdata,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/fp_mult_result_buffer.sv
// ============================================================================
// Module      : fp_mult_result_buffer
// Description : Buffers fp_mult results in a FWFT FIFO with early credit,
//               sticky exception flags and saturating result/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mult_result_buffer
    import fp_mult_result_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    fp_mult_result_buffer_if.slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WIDTH = STATUS_W + Z_W;
    localparam logic [AW:0]      AF_LEVEL = (AW+1)'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] head;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic             accept_ready;
    fp_status_t       in_st;

    logic [FLAG_W-1:0] sticky_flags;
    logic [CNT_W-1:0]  result_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              overflow_err;

    assign in_st        = fp_status_t'(bus.in_status);
    assign pop          = ~empty & bus.out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign accept_ready = ~full | pop;
    assign push         = bus.in_valid & accept_ready;
    assign drop         = bus.in_valid & ~accept_ready;

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.in_status, bus.in_z}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
            result_cnt   <= '0;
            drop_cnt     <= '0;
            overflow_err <= 1'b0;
        end else if (bus.clear_flags) begin
            // Clear wins over history but not over this cycle's event.
            sticky_flags <= push ? status_flags(in_st) : '0;
            result_cnt   <= push ? CNT_ONE : '0;
            drop_cnt     <= drop ? CNT_ONE : '0;
            overflow_err <= drop;
        end else begin
            if (push) begin
                sticky_flags <= sticky_flags | status_flags(in_st);
                if (result_cnt != CNT_MAX) begin
                    result_cnt <= result_cnt + CNT_ONE;
                end
            end
            if (drop) begin
                overflow_err <= 1'b1;
                if (drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + CNT_ONE;
                end
            end
        end
    end

    assign bus.in_ready     = accept_ready;
    // Credit comes from registered count only, covering issue-to-valid latency.
    assign bus.almost_full  = (count >= AF_LEVEL);
    assign bus.out_valid    = ~empty;
    assign bus.out_z        = empty ? '0 : head[Z_W-1:0];
    assign bus.out_status   = empty ? '0 : head[WIDTH-1:Z_W];
    assign bus.sticky_flags = sticky_flags;
    assign bus.result_cnt   = result_cnt;
    assign bus.drop_cnt     = drop_cnt;
    assign bus.overflow_err = overflow_err;

endmodule

`default_nettype wire

// File: tb/tb_fp_mult_result_buffer.sv
// ============================================================================
// Module      : tb_fp_mult_result_buffer
// Description : Directed + random bench for fp_mult_result_buffer (CNT_W=16
//               and CNT_W=2 instances share stimulus) against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mult_result_buffer;
    import fp_mult_result_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int SAT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid    = 1'b0;
    logic [31:0] in_z        = '0;
    logic [7:0]  in_status   = '0;
    logic        out_ready   = 1'b0;
    logic        clear_flags = 1'b0;

    fp_mult_result_buffer_if #(.CNT_W(CNT_W)) bus ();
    fp_mult_result_buffer_if #(.CNT_W(SAT_W)) bus_s ();

    assign bus.in_valid      = in_valid;
    assign bus.in_z          = in_z;
    assign bus.in_status     = in_status;
    assign bus.out_ready     = out_ready;
    assign bus.clear_flags   = clear_flags;
    assign bus_s.in_valid    = in_valid;
    assign bus_s.in_z        = in_z;
    assign bus_s.in_status   = in_status;
    assign bus_s.out_ready   = out_ready;
    assign bus_s.clear_flags = clear_flags;

    fp_mult_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    fp_mult_result_buffer #(.DEPTH(DEPTH), .CNT_W(SAT_W)) dut_sat (
        .clk (clk), .rst (rst), .bus (bus_s)
    );

    // Reference model: queue of {status, z} plus plain integer counters.
    logic [39:0] q[$];
    logic [5:0]  m_sticky;
    logic        m_ovf;
    int          m_rcnt, m_dcnt, m_rcnt_s, m_dcnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int sat_inc(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v >= m) ? m : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sticky = '0; m_ovf = 1'b0;
        m_rcnt = 0; m_dcnt = 0; m_rcnt_s = 0; m_dcnt_s = 0;
    endtask

    task automatic check_counters();
        chk("sticky_flags", 64'(bus.sticky_flags), 64'(m_sticky));
        chk("result_cnt",   64'(bus.result_cnt),   64'(m_rcnt));
        chk("drop_cnt",     64'(bus.drop_cnt),     64'(m_dcnt));
        chk("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
        chk("sat_result_cnt", 64'(bus_s.result_cnt), 64'(m_rcnt_s));
        chk("sat_drop_cnt",   64'(bus_s.drop_cnt),   64'(m_dcnt_s));
    endtask

    // One clock: drive, check combinational view, clock, update model, check state.
    task automatic cyc(input logic v, input logic [31:0] z, input logic [7:0] st,
                       input logic rdy, input logic clr);
        bit do_pop, rdy_ok, do_push, do_drop;
        in_valid = v; in_z = z; in_status = st; out_ready = rdy; clear_flags = clr;
        #1;
        do_pop  = (q.size() != 0) && rdy;
        rdy_ok  = (q.size() < DEPTH) || do_pop;
        do_push = v && rdy_ok;
        do_drop = v && !rdy_ok;
        chk("out_valid",   64'(bus.out_valid), 64'(q.size() != 0));
        chk("out_z",       64'(bus.out_z),      (q.size() != 0) ? 64'(q[0][31:0])  : 64'(0));
        chk("out_status",  64'(bus.out_status), (q.size() != 0) ? 64'(q[0][39:32]) : 64'(0));
        chk("in_ready",    64'(bus.in_ready),    64'(rdy_ok));
        chk("almost_full", 64'(bus.almost_full), 64'(q.size() >= DEPTH - 1));
        @(posedge clk);
        #1;
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back({st, z});
        if (clr) begin
            m_sticky = '0; m_ovf = 1'b0;
            m_rcnt = 0; m_dcnt = 0; m_rcnt_s = 0; m_dcnt_s = 0;
        end
        if (do_push) begin
            m_sticky = m_sticky | st[5:0];
            m_rcnt   = sat_inc(m_rcnt, CNT_W);
            m_rcnt_s = sat_inc(m_rcnt_s, SAT_W);
        end
        if (do_drop) begin
            m_ovf    = 1'b1;
            m_dcnt   = sat_inc(m_dcnt, CNT_W);
            m_dcnt_s = sat_inc(m_dcnt_s, SAT_W);
        end
        check_counters();
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, 8'h0, rdy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid),    64'(0));
        chk({tag, "_out_z"},     64'(bus.out_z),        64'(0));
        chk({tag, "_out_st"},    64'(bus.out_status),   64'(0));
        chk({tag, "_sticky"},    64'(bus.sticky_flags), 64'(0));
        chk({tag, "_rcnt"},      64'(bus.result_cnt),   64'(0));
        chk({tag, "_dcnt"},      64'(bus.drop_cnt),     64'(0));
        chk({tag, "_ovf"},       64'(bus.overflow_err), 64'(0));
        chk({tag, "_af"},        64'(bus.almost_full),  64'(0));
        chk({tag, "_in_ready"},  64'(bus.in_ready),     64'(1));
    endtask

    initial begin
        model_reset();
        // Asynchronous reset visible before the first clock edge.
        #3;
        check_reset_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1'b0);

        // Single pass: latency 1 from in_valid to out_valid.
        cyc(1'b1, 32'h40C00000, 8'h00, 1'b1, 1'b0);
        chk("single_out_z", 64'(bus.out_z), 64'h40C00000);
        idle(1'b1);
        chk("single_empty", 64'(bus.out_valid), 64'(0));
        chk("single_rcnt",  64'(bus.result_cnt), 64'(1));

        // Fill and drop with consumer stalled.
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h3F800000 + 32'(i), 8'h00, 1'b0, 1'b0);
            if (i == 2) chk("fill_af_after3", 64'(bus.almost_full), 64'(1));
            if (i == 3) chk("fill_nready_after4", 64'(bus.in_ready), 64'(0));
        end
        chk("fill_drop_cnt", 64'(bus.drop_cnt),     64'(1));
        chk("fill_ovf",      64'(bus.overflow_err), 64'(1));
        chk("fill_rcnt",     64'(bus.result_cnt),   64'(4));

        // Full with push and pop together: accepted, new entry lands last.
        cyc(1'b1, 32'hAAAA0005, 8'h00, 1'b1, 1'b0);
        chk("full_pp_drop_cnt", 64'(bus.drop_cnt), 64'(1));
        chk("full_pp_head",     64'(bus.out_z),    64'h3F800001);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Sticky flag accumulation.
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h3F800000, 8'h20, 1'b0, 1'b0);
        cyc(1'b1, 32'h7F800000, 8'h02, 1'b0, 1'b0);
        cyc(1'b1, 32'h7FC00000, 8'h04, 1'b0, 1'b0);
        chk("sticky_mix", 64'(bus.sticky_flags), 64'(6'b100110));
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Clear colliding with a push.
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h11110000, 8'h02, 1'b0, 1'b0);
        cyc(1'b1, 32'h11110001, 8'h04, 1'b0, 1'b0);
        cyc(1'b1, 32'h11110002, 8'h00, 1'b0, 1'b0);
        chk("pre_clear_sticky", 64'(bus.sticky_flags), 64'(6'b000110));
        cyc(1'b1, 32'h11110003, 8'h01, 1'b0, 1'b1);
        chk("clr_push_sticky", 64'(bus.sticky_flags), 64'(6'b000001));
        chk("clr_push_rcnt",   64'(bus.result_cnt),   64'(1));
        chk("clr_push_dcnt",   64'(bus.drop_cnt),     64'(0));
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Wrap-around streaming and CNT_W=2 saturation.
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h50000000 + 32'(i), 8'(i), 1'b1, 1'b0);
        idle(1'b1);
        chk("wrap_no_drop", 64'(bus.drop_cnt),     64'(0));
        chk("wrap_rcnt",    64'(bus.result_cnt),   64'(10));
        chk("sat_rcnt_3",   64'(bus_s.result_cnt), 64'(3));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
        end

        // Mid-stream asynchronous reset discards buffered entries.
        cyc(1'b1, 32'hDEAD0001, 8'h10, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD0002, 8'h08, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(1'b1);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
